nco_iq: RTL
===========

# nco_iq

Parametrised, phase-coherent numerically controlled oscillator producing signed quadrature sine/cosine samples plus legacy square-wave outputs. It succeeds the single-bit square-wave NCO in the SDR front end and drives the digital down-converter mixer. Added over its predecessor: a handshaked, double-buffered frequency update with optional wrap-synchronous application, a programmable phase offset, a quarter-wave LUT amplitude path, and a clock enable with output valid.

## Interface
- ACC_WIDTH, 64, phase accumulator and increment width (≥ PHASE_BITS+2)
- PHASE_BITS, 10, LUT phase address width (≥ 4)
- AMP_WIDTH, 12, signed sample width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  accumulator advances when 1
- inc_in  in  ACC_WIDTH  new phase increment
- inc_valid  in  1  inc_in offered
- inc_ready  out  1  update slot free
- sync_mode  in  1  0 = apply immediately, 1 = apply at next accumulator wrap
- phase_offset  in  PHASE_BITS  added to phase address, sampled every cycle
- phase_acc  out  ACC_WIDTH  accumulator
- wrap  out  1  one-cycle pulse when accumulator carried out
- sin_sq, cos_sq  out  1  square outputs from phase_acc MSBs
- sin_out, cos_out  out  AMP_WIDTH  signed samples
- out_valid  out  1  sample qualifier

## Operation
- Active increment register inc_act; pending register inc_pend with flag pend.
- inc_ready = !pend. Transfer when inc_valid && inc_ready.
- Transfer with sync_mode=0: inc_act <= inc_in next edge; pend stays 0.
- Transfer with sync_mode=1: inc_pend <= inc_in, pend <= 1.
- With pend=1, on an edge where en=1 and phase_acc + inc_act carries out of ACC_WIDTH: accumulator update uses old inc_act; inc_act <= inc_pend, pend <= 0 on that edge.
- Transfer and carry on the same edge: the new value is pended and applied at the following wrap, not this one.
- en=1: phase_acc <= phase_acc + inc_act (mod 2^ACC_WIDTH); wrap registered from carry. en=0: accumulator holds, wrap=0; updates still accepted.
- sin_sq = !phase_acc[MSB]; cos_sq = !(phase_acc[MSB] ^ phase_acc[MSB-1]).
- Amplitude path: addr = phase_acc[MSB -: PHASE_BITS] + phase_offset (mod 2^PHASE_BITS); cosine address = addr + 2^(PHASE_BITS-2).
- Fold: q = addr[top 2 bits], idx = low bits, inverted when q[0]=1; negate LUT value when q[1]=1.
- LUT entry i = round((2^(AMP_WIDTH-1)-1)·sin(2π(i+0.5)/2^PHASE_BITS)), i in 0..2^(PHASE_BITS-2)-1; half-LSB offset makes the fold exact; no negative full-scale ever produced.

## Timing
- Reset: phase_acc=0, inc_act=0, inc_pend=0, pend=0 (inc_ready=1), wrap=0, sin_out=cos_out=0, out_valid=0; sin_sq=cos_sq=1 from phase_acc=0.
- Stage 0 address/offset register, stage 1 fold, stage 2 LUT read, stage 3 sign: sin_out/cos_out valid 3 cycles after the phase_acc value they represent.
- out_valid = en delayed to align with samples (3-stage shift, reset 0); pipeline always advances.
- Immediate update affects the increment added on the edge after acceptance.
- Reset mid-operation clears pipeline and any pending update immediately (asynchronous), deasserts out_valid.

## Configuration
- NCO_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, steps when en=1) added to the accumulator bits just below the phase address before truncation (LFSR MSB-aligned to bit MSB-PHASE_BITS); spreads truncation spurs. Square outputs and phase_acc unaffected.
- Undefined: plain truncation; no LFSR logic.

## Structure
- nco_pkg: LUT depth/index width functions, quadrant encoding constants, LFSR seed and tap mask.
- Sub-module nco_quarter_lut: registered quarter-wave ROM, generated at elaboration from AMP_WIDTH/PHASE_BITS; instantiated twice (sin, cos) or dual-read.

## Test plan
- Reset: assert rst_n=0 mid-run -> all outputs at reset values within the same cycle, inc_ready=1.
- inc_in=2^62, sync_mode=0, offset 0, defaults -> phase address 0,256,512,768 repeating; sin_out 6,2047,-6,-2047; cos_out 2047,-6,-2047,6, 3 cycles later; wrap every 4th cycle.
- Same run, phase_offset=256 -> sin_out sequence equals previous cos_out.
- sync_mode=1, offer inc_in=2^61 while running at 2^62 -> inc_ready low until wrap edge; period becomes 8 from that wrap; no phase discontinuity.
- Offer update on the exact wrap edge in sync mode -> applied at the next wrap (4 cycles later).
- en toggled 1,0,1 -> phase_acc holds during en=0, out_valid mirrors en delayed 3 cycles.

Source files
------------

// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
// Shared definitions for the quadrature NCO:
//   - quarter-wave LUT depth / index width helpers
//   - LUT contents generator (evaluated at elaboration)
//   - quadrant encoding of the two phase-address MSBs
//   - dither LFSR seed, tap mask and step function (used only when the
//     NCO_DITHER_EN macro is defined in nco_iq)
// -----------------------------------------------------------------------------
package nco_pkg;

  // Quadrant of the phase address (top two address bits).
  // Bit 0 set -> index mirrored; bit 1 set -> LUT value negated.
  typedef enum logic [1:0] {
    QUAD_I   = 2'd0,
    QUAD_II  = 2'd1,
    QUAD_III = 2'd2,
    QUAD_IV  = 2'd3
  } quad_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam real PI = 3.14159265358979323846;

  // Number of entries in the quarter-wave table
  function automatic int lut_depth(input int phase_bits);
    return 32'sd1 <<< (phase_bits - 32'sd2);
  endfunction

  // Width of the quarter-wave table index
  function automatic int lut_idx_w(input int phase_bits);
    return phase_bits - 32'sd2;
  endfunction

  // Sine on [0, pi/2] by Taylor series; the x^17 remainder is far below
  // one LSB of any practical sample width.
  function automatic real quarter_sin(input real x);
    real term_v;
    real sum_v;
    term_v = x;
    sum_v  = x;
    for (int k = 1; k <= 8; k++) begin
      term_v = -term_v * x * x / (real'(2 * k) * real'(2 * k + 1));
      sum_v  = sum_v + term_v;
    end
    return sum_v;
  endfunction

  // Table entry i: sampled at the half-LSB phase point so that the mirrored
  // second quadrant reproduces exactly the same magnitudes.
  function automatic int lut_value(input int i, input int phase_bits, input int amp_width);
    real amp_v;
    real ang_v;
    amp_v = real'((32'd1 << (amp_width - 1)) - 32'd1);
    ang_v = 2.0 * PI * (real'(i) + 0.5) / real'(32'd1 << phase_bits);
    return $rtoi(amp_v * quarter_sin(ang_v) + 0.5);
  endfunction

  // One LFSR step
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// -----------------------------------------------------------------------------
// nco_quarter_lut
// Registered quarter-wave sine ROM. Contents are generated at elaboration from
// PHASE_BITS / AMP_WIDTH; entries are unsigned magnitudes (sign applied later).
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears the read register)
//   idx    in   PHASE_BITS-2 bit table index
//   mag    out  AMP_WIDTH-1 bit registered magnitude
// -----------------------------------------------------------------------------
module nco_quarter_lut
  import nco_pkg::*;
#(
  parameter int PHASE_BITS = 10,
  parameter int AMP_WIDTH  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PHASE_BITS-3:0]   idx,
  output logic [AMP_WIDTH-2:0]    mag
);

  localparam int DEPTH = lut_depth(PHASE_BITS);

  logic [AMP_WIDTH-2:0] rom_s [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam int VAL = lut_value(i, PHASE_BITS, AMP_WIDTH);
    assign rom_s[i] = VAL[AMP_WIDTH-2:0];
  end

  // Registered ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
    end else begin
      mag <= rom_s[idx];
    end
  end

endmodule

// File: rtl/nco_iq.sv
// -----------------------------------------------------------------------------
// nco_iq
// Phase-coherent quadrature NCO with handshaked, double-buffered frequency
// update, programmable phase offset, quarter-wave LUT amplitude path and
// legacy square-wave outputs.
//
// Optional feature: define NCO_DITHER_EN to add a 16-bit LFSR phase dither
// just below the LUT address before truncation (phase_acc and the square
// outputs are unaffected).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   accumulator advances when 1
//   inc_in/inc_valid     offered phase increment
//   inc_ready            update slot free (no update pending)
//   sync_mode            0 = apply at next edge, 1 = apply at next wrap
//   phase_offset         added to the LUT phase address each cycle
//   phase_acc            phase accumulator
//   wrap                 one-cycle pulse after accumulator carry-out
//   sin_sq, cos_sq       square outputs decoded from phase_acc MSBs
//   sin_out, cos_out     signed samples, 3 cycles behind phase_acc
//   out_valid            sample qualifier (en delayed 3 cycles)
// -----------------------------------------------------------------------------
module nco_iq
  import nco_pkg::*;
#(
  parameter int ACC_WIDTH  = 64,
  parameter int PHASE_BITS = 10,
  parameter int AMP_WIDTH  = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [ACC_WIDTH-1:0]         inc_in,
  input  logic                         inc_valid,
  output logic                         inc_ready,
  input  logic                         sync_mode,
  input  logic [PHASE_BITS-1:0]        phase_offset,
  output logic [ACC_WIDTH-1:0]         phase_acc,
  output logic                         wrap,
  output logic                         sin_sq,
  output logic                         cos_sq,
  output logic signed [AMP_WIDTH-1:0]  sin_out,
  output logic signed [AMP_WIDTH-1:0]  cos_out,
  output logic                         out_valid
);

  localparam int IDX_W = lut_idx_w(PHASE_BITS);
  localparam logic [PHASE_BITS-1:0] QTR = PHASE_BITS'(32'd1 << (PHASE_BITS - 2));

  // ---------------------------------------------------------------------------
  // Increment handshake and accumulator
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] inc_act_r;
  logic [ACC_WIDTH-1:0] inc_pend_r;
  logic                 pend_r;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 carry_s;
  logic                 xfer_s;

  assign sum_s     = {1'b0, phase_acc} + {1'b0, inc_act_r};
  assign carry_s   = sum_s[ACC_WIDTH];
  assign inc_ready = !pend_r;
  assign xfer_s    = inc_valid && !pend_r;

  // Phase accumulator and registered carry pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
      wrap      <= 1'b0;
    end else if (en) begin
      phase_acc <= sum_s[ACC_WIDTH-1:0];
      wrap      <= carry_s;
    end else begin
      wrap      <= 1'b0;
    end
  end

  // Active/pending increment registers. A transfer needs pend_r=0, so a
  // pended value can never be swapped in on the edge it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_act_r  <= '0;
      inc_pend_r <= '0;
      pend_r     <= 1'b0;
    end else begin
      if (xfer_s && !sync_mode) begin
        inc_act_r <= inc_in;
      end else if (pend_r && en && carry_s) begin
        inc_act_r <= inc_pend_r;
        pend_r    <= 1'b0;
      end
      if (xfer_s && sync_mode) begin
        inc_pend_r <= inc_in;
        pend_r     <= 1'b1;
      end
    end
  end

  assign sin_sq = !phase_acc[ACC_WIDTH-1];
  assign cos_sq = !(phase_acc[ACC_WIDTH-1] ^ phase_acc[ACC_WIDTH-2]);

  // ---------------------------------------------------------------------------
  // Phase address (optionally dithered)
  // ---------------------------------------------------------------------------
  logic [PHASE_BITS-1:0] base_addr_s;

`ifdef NCO_DITHER_EN
  logic [15:0]           lfsr_r;
  logic [ACC_WIDTH+15:0] dith_sum_s;

  // Dither LFSR steps together with the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else if (en) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // LFSR MSB lands one bit below the LUT address LSB
  assign dith_sum_s  = {phase_acc, 16'd0}
                     + ({{ACC_WIDTH{1'b0}}, lfsr_r} << (ACC_WIDTH - PHASE_BITS));
  assign base_addr_s = dith_sum_s[ACC_WIDTH+15 -: PHASE_BITS];
`else
  assign base_addr_s = phase_acc[ACC_WIDTH-1 -: PHASE_BITS];
`endif

  // ---------------------------------------------------------------------------
  // Amplitude pipeline: address register -> fold + LUT read -> sign
  // ---------------------------------------------------------------------------
  logic [PHASE_BITS-1:0] sin_addr_r;
  logic [PHASE_BITS-1:0] cos_addr_r;

  // Address/offset register; cosine leads sine by a quarter turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_addr_r <= '0;
      cos_addr_r <= '0;
    end else begin
      sin_addr_r <= base_addr_s + phase_offset;
      cos_addr_r <= base_addr_s + phase_offset + QTR;
    end
  end

  // Quadrant fold: returns {negate, table index}
  function automatic logic [IDX_W:0] fold(input logic [PHASE_BITS-1:0] a);
    logic [IDX_W-1:0] low_v;
    low_v = a[IDX_W-1:0];
    case (quad_e'(a[PHASE_BITS-1 -: 2]))
      QUAD_I:   fold = {1'b0, low_v};
      QUAD_II:  fold = {1'b0, ~low_v};
      QUAD_III: fold = {1'b1, low_v};
      QUAD_IV:  fold = {1'b1, ~low_v};
      default:  fold = {1'b0, low_v};
    endcase
  endfunction

  logic [IDX_W:0]       sin_fold_s;
  logic [IDX_W:0]       cos_fold_s;
  logic [AMP_WIDTH-2:0] sin_mag_s;
  logic [AMP_WIDTH-2:0] cos_mag_s;
  logic                 sin_neg_r;
  logic                 cos_neg_r;

  assign sin_fold_s = fold(sin_addr_r);
  assign cos_fold_s = fold(cos_addr_r);

  nco_quarter_lut #(
    .PHASE_BITS (PHASE_BITS),
    .AMP_WIDTH  (AMP_WIDTH)
  ) u_sin_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (sin_fold_s[IDX_W-1:0]),
    .mag   (sin_mag_s)
  );

  nco_quarter_lut #(
    .PHASE_BITS (PHASE_BITS),
    .AMP_WIDTH  (AMP_WIDTH)
  ) u_cos_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (cos_fold_s[IDX_W-1:0]),
    .mag   (cos_mag_s)
  );

  // Negate flags travel alongside the LUT read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_neg_r <= 1'b0;
      cos_neg_r <= 1'b0;
    end else begin
      sin_neg_r <= sin_fold_s[IDX_W];
      cos_neg_r <= cos_fold_s[IDX_W];
    end
  end

  logic [AMP_WIDTH-1:0] sin_ext_s;
  logic [AMP_WIDTH-1:0] cos_ext_s;

  assign sin_ext_s = {1'b0, sin_mag_s};
  assign cos_ext_s = {1'b0, cos_mag_s};

  // Sign stage; magnitudes never exceed 2^(AMP_WIDTH-1)-1 so no overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      sin_out <= sin_neg_r ? -sin_ext_s : sin_ext_s;
      cos_out <= cos_neg_r ? -cos_ext_s : cos_ext_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Output qualifier: en delayed to line up with the sample pipeline
  // ---------------------------------------------------------------------------
  logic [1:0] vld_r;

  // Valid shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r     <= 2'b00;
      out_valid <= 1'b0;
    end else begin
      vld_r     <= {vld_r[0], en};
      out_valid <= vld_r[1];
    end
  end

endmodule
